lc3b_imm_decode: RTL and testbench

- Two-stage pipelined instruction-register and immediate-generation stage that feeds the sign extender.
- Accepts fetched LC-3b instructions over a valid/ready handshake and latches each into an instruction register.
- Selects the opcode-specific immediate field, sign- or zero-extends it to 16 bits, applies the LC-3b word shift, and optionally forms a PC-relative target.
- Delivers the result downstream to the register-read/ALU stage over a second valid/ready handshake.

---
 rtl/lc3b_imm_decode_if.sv | 30 +++
 rtl/lc3b_imm_decode.sv | 192 +++++++++++++++++++
 tb/tb_lc3b_imm_decode.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_imm_decode_if.sv
// Handshake bundle for the LC-3b immediate-decode stage: upstream fetch
// channel (in_*) and downstream register-read/ALU channel (out_*).
interface lc3b_imm_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic        out_imm_used;
  logic        out_pc_rel;
  logic [15:0] out_target;
  logic        out_illegal;

  // Environment side: drives instructions and downstream ready.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_imm_used,
           out_pc_rel, out_target, out_illegal
  );

  // Decode-stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_imm_used,
           out_pc_rel, out_target, out_illegal
  );
endinterface

// File: rtl/lc3b_imm_decode.sv
// LC-3b instruction register + immediate generator.
// Stage 1 latches the fetched instruction and PC+2; stage 2 registers the
// extended/shifted immediate, flags and optional PC-relative target.
module lc3b_imm_decode #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_50,
  input  logic                 reset,
  lc3b_imm_decode_if.slave     bus,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDW  = 4'h6,
    OP_STW  = 4'h7,
    OP_RTI  = 4'h8,
    OP_XOR  = 4'h9,
    OP_RSVA = 4'hA,
    OP_RSVB = 4'hB,
    OP_JMP  = 4'hC,
    OP_SHF  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  // Stage 1 (instruction register)
  logic                 r_s1_valid;
  logic [15:0]          r_s1_instr;
  logic [15:0]          r_s1_pc;

  // Stage 2 (decoded result)
  logic                 r_s2_valid;
  logic [15:0]          r_s2_instr;
  logic [15:0]          r_s2_imm;
  logic                 r_s2_used;
  logic                 r_s2_pc_rel;
  logic [15:0]          r_s2_target;
  logic                 r_s2_illegal;

  logic [CNT_WIDTH-1:0] r_illegal_count;

  // Pipeline control
  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_accept;
  logic                 w_deliver;

  // Decode of the stage-1 instruction
  opcode_e              w_opcode;
  logic [15:0]          w_imm;
  logic                 w_used;
  logic                 w_pc_rel;
  logic                 w_illegal;
  logic [15:0]          w_target;

  // Handshake/advance logic: a stage may advance when empty or when its
  // consumer is taking the current contents.
  always_comb begin
    w_s2_adv  = !r_s2_valid || bus.out_ready;
    w_s1_adv  = !r_s1_valid || w_s2_adv;
    w_accept  = bus.in_valid && w_s1_adv;
    w_deliver = r_s2_valid && bus.out_ready;
  end

  assign w_opcode = opcode_e'(r_s1_instr[15:12]);

  // Opcode-specific field select, extension and word shift.
  // Shifted forms drop the extended MSB, so the sign copy count is one less.
  always_comb begin
    w_imm     = '0;
    w_used    = 1'b0;
    w_pc_rel  = 1'b0;
    w_illegal = 1'b0;
    unique case (w_opcode)
      OP_ADD, OP_AND, OP_XOR: begin
        if (r_s1_instr[5]) begin
          w_imm  = {{11{r_s1_instr[4]}}, r_s1_instr[4:0]};
          w_used = 1'b1;
        end
      end
      OP_BR, OP_LEA: begin
        w_imm    = {{6{r_s1_instr[8]}}, r_s1_instr[8:0], 1'b0};
        w_used   = 1'b1;
        w_pc_rel = 1'b1;
      end
      OP_JSR: begin
        if (r_s1_instr[11]) begin
          w_imm    = {{4{r_s1_instr[10]}}, r_s1_instr[10:0], 1'b0};
          w_used   = 1'b1;
          w_pc_rel = 1'b1;
        end
      end
      OP_LDB, OP_STB: begin
        w_imm  = {{10{r_s1_instr[5]}}, r_s1_instr[5:0]};
        w_used = 1'b1;
      end
      OP_LDW, OP_STW: begin
        w_imm  = {{9{r_s1_instr[5]}}, r_s1_instr[5:0], 1'b0};
        w_used = 1'b1;
      end
      OP_SHF: begin
        w_imm  = {12'h000, r_s1_instr[3:0]};
        w_used = 1'b1;
      end
      OP_TRAP: begin
        w_imm  = {7'h00, r_s1_instr[7:0], 1'b0};
        w_used = 1'b1;
      end
      OP_JMP, OP_RTI: begin
        w_used = 1'b0;
      end
      OP_RSVA, OP_RSVB: begin
        w_illegal = 1'b1;
      end
      default: begin
        w_illegal = 1'b0;
      end
    endcase
  end

  // PC-relative target, 16-bit wrap-around add.
  always_comb begin
    w_target = '0;
    if (w_pc_rel) begin
      w_target = r_s1_pc + w_imm;
    end
  end

  // Stage 1 register: load on accept, otherwise drain when stage 2 moves.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_instr <= '0;
      r_s1_pc    <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_instr <= bus.in_instr;
      r_s1_pc    <= bus.in_pc;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: takes stage 1 whenever it may advance; holds otherwise.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_s2_valid   <= 1'b0;
      r_s2_instr   <= '0;
      r_s2_imm     <= '0;
      r_s2_used    <= 1'b0;
      r_s2_pc_rel  <= 1'b0;
      r_s2_target  <= '0;
      r_s2_illegal <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr   <= r_s1_instr;
        r_s2_imm     <= w_imm;
        r_s2_used    <= w_used;
        r_s2_pc_rel  <= w_pc_rel;
        r_s2_target  <= w_target;
        r_s2_illegal <= w_illegal;
      end
    end
  end

  // Saturating count of illegal instructions actually handed downstream.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_illegal_count <= '0;
    end else if (w_deliver && r_s2_illegal && (r_illegal_count != '1)) begin
      r_illegal_count <= r_illegal_count + CNT_WIDTH'(1);
    end
  end

  assign bus.in_ready     = w_s1_adv;
  assign bus.out_valid    = r_s2_valid;
  assign bus.out_instr    = r_s2_instr;
  assign bus.out_imm      = r_s2_imm;
  assign bus.out_imm_used = r_s2_used;
  assign bus.out_pc_rel   = r_s2_pc_rel;
  assign bus.out_target   = r_s2_target;
  assign bus.out_illegal  = r_s2_illegal;
  assign illegal_count    = r_illegal_count;

endmodule

// File: tb/tb_lc3b_imm_decode.sv
// Bench for lc3b_imm_decode: vector table pushed through a scoreboard
// queue, plus hand sequences for latency, backpressure, reset and saturation.
module tb_lc3b_imm_decode;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] imm;
    logic        used;
    logic        pcrel;
    logic [15:0] target;
    logic        illegal;
  } vec_t;

  logic       clk_50 = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] illegal_count;

  lc3b_imm_decode_if bus();

  lc3b_imm_decode #(.CNT_WIDTH(8)) dut (
    .clk_50        (clk_50),
    .reset         (reset),
    .bus           (bus),
    .illegal_count (illegal_count)
  );

  always #5 clk_50 = ~clk_50;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur_exp;
  int   n_ill = 0;
  logic done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] instr, input logic [15:0] pc,
                              input logic [15:0] imm, input logic used,
                              input logic pcrel, input logic [15:0] target,
                              input logic illegal);
    vec_t v;
    v.instr = instr; v.pc = pc; v.imm = imm; v.used = used;
    v.pcrel = pcrel; v.target = target; v.illegal = illegal;
    return v;
  endfunction

  // Scoreboard: push at input handshake, pop and compare at output handshake.
  always @(negedge clk_50) begin
    if (!reset) begin
      if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected: got instr 0x%0h expected no output", bus.out_instr);
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("out_instr",    {16'h0, bus.out_instr},       {16'h0, e.instr});
          chk("out_imm",      {16'h0, bus.out_imm},         {16'h0, e.imm});
          chk("out_imm_used", {31'h0, bus.out_imm_used},    {31'h0, e.used});
          chk("out_pc_rel",   {31'h0, bus.out_pc_rel},      {31'h0, e.pcrel});
          chk("out_target",   {16'h0, bus.out_target},      {16'h0, e.target});
          chk("out_illegal",  {31'h0, bus.out_illegal},     {31'h0, e.illegal});
        end
      end
    end
  end

  task automatic send(input vec_t v);
    int unsigned n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = v.instr;
    bus.in_pc    = v.pc;
    cur_exp      = v;
    @(negedge clk_50);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk_50);
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk_50);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      n++;
      @(negedge clk_50);
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    sb.delete();
    repeat (2) @(posedge clk_50);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_t a, b, c, ill;
    #4000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t a, b, c, ill;
    bus.out_ready = 1'b1;
    idle();

    vecs.push_back(mk(16'h12BD, 16'h3000, 16'hFFFD, 1, 0, 16'h0000, 0)); // ADD imm -3
    vecs.push_back(mk(16'h1283, 16'h3000, 16'h0000, 0, 0, 16'h0000, 0)); // ADD reg
    vecs.push_back(mk(16'h5A2F, 16'h1234, 16'h000F, 1, 0, 16'h0000, 0)); // AND imm +15
    vecs.push_back(mk(16'h9A3F, 16'h1234, 16'hFFFF, 1, 0, 16'h0000, 0)); // XOR imm -1
    vecs.push_back(mk(16'h0FFF, 16'h3002, 16'hFFFE, 1, 1, 16'h3000, 0)); // BR -1 word
    vecs.push_back(mk(16'h0E03, 16'hFFFE, 16'h0006, 1, 1, 16'h0004, 0)); // BR wrap
    vecs.push_back(mk(16'hE100, 16'h4000, 16'hFE00, 1, 1, 16'h3E00, 0)); // LEA min offset
    vecs.push_back(mk(16'h4FFF, 16'h5000, 16'hFFFE, 1, 1, 16'h4FFE, 0)); // JSR -1
    vecs.push_back(mk(16'h4C00, 16'h1000, 16'hF800, 1, 1, 16'h0800, 0)); // JSR min
    vecs.push_back(mk(16'h4080, 16'h1000, 16'h0000, 0, 0, 16'h0000, 0)); // JSRR
    vecs.push_back(mk(16'h2020, 16'h2000, 16'hFFE0, 1, 0, 16'h0000, 0)); // LDB
    vecs.push_back(mk(16'h303F, 16'h2000, 16'hFFFF, 1, 0, 16'h0000, 0)); // STB
    vecs.push_back(mk(16'h6020, 16'h2000, 16'hFFC0, 1, 0, 16'h0000, 0)); // LDW
    vecs.push_back(mk(16'h701F, 16'h2000, 16'h003E, 1, 0, 16'h0000, 0)); // STW
    vecs.push_back(mk(16'hD00F, 16'h2000, 16'h000F, 1, 0, 16'h0000, 0)); // SHF
    vecs.push_back(mk(16'hF025, 16'h2000, 16'h004A, 1, 0, 16'h0000, 0)); // TRAP
    vecs.push_back(mk(16'hF0FF, 16'h2000, 16'h01FE, 1, 0, 16'h0000, 0)); // TRAP max
    vecs.push_back(mk(16'hC1C0, 16'h2000, 16'h0000, 0, 0, 16'h0000, 0)); // JMP
    vecs.push_back(mk(16'h8000, 16'h2000, 16'h0000, 0, 0, 16'h0000, 0)); // RTI
    vecs.push_back(mk(16'hA000, 16'h2000, 16'h0000, 0, 0, 16'h0000, 1)); // illegal
    vecs.push_back(mk(16'hB123, 16'h2000, 16'h0000, 0, 0, 16'h0000, 1)); // illegal
    foreach (vecs[i]) if (vecs[i].illegal) n_ill++;
    ill = mk(16'hA000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1);

    // Reset state
    do_reset();
    @(negedge clk_50);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
    chk("rst_count",     {24'h0, illegal_count}, 32'h0);
    chk("rst_out_imm",   {16'h0, bus.out_imm},   32'h0);
    chk("rst_target",    {16'h0, bus.out_target}, 32'h0);
    @(posedge clk_50); #1;

    // Two-cycle latency on an empty pipeline
    send(vecs[0]);
    idle();
    @(negedge clk_50);
    chk("lat_n1_valid", {31'h0, bus.out_valid}, 32'h0);
    @(negedge clk_50);
    chk("lat_n2_valid", {31'h0, bus.out_valid}, 32'h1);
    drain();

    // Illegal: counter steps exactly at the output handshake
    send(ill);
    idle();
    @(negedge clk_50);
    @(negedge clk_50);
    chk("ill_valid",     {31'h0, bus.out_valid},   32'h1);
    chk("ill_pre_count", {24'h0, illegal_count},   32'h0);
    @(posedge clk_50); #1;
    chk("ill_post_count", {24'h0, illegal_count},  32'h1);
    drain();

    // Table, back-to-back with downstream always ready
    foreach (vecs[i]) send(vecs[i]);
    idle();
    drain();
    chk("tbl1_count", {24'h0, illegal_count}, 32'(1 + n_ill));

    // Table again with random downstream backpressure
    done = 1'b0;
    fork
      begin
        foreach (vecs[i]) send(vecs[i]);
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_50); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("tbl2_count", {24'h0, illegal_count}, 32'(1 + 2 * n_ill));

    // Backpressure: A, B held, C stalled, then streamed in order
    a = vecs[0]; b = vecs[12]; c = vecs[15];
    bus.out_ready = 1'b0;
    fork
      begin
        send(a); send(b); send(c);
        idle();
      end
      begin
        repeat (2) @(posedge clk_50);
        repeat (4) begin
          @(negedge clk_50);
          chk("bp_in_ready",  {31'h0, bus.in_ready},  32'h0);
          chk("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
          chk("bp_hold_instr", {16'h0, bus.out_instr}, {16'h0, a.instr});
          chk("bp_hold_imm",   {16'h0, bus.out_imm},   {16'h0, a.imm});
        end
        @(posedge clk_50); #1;
        bus.out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk_50);
          chk("bp_stream_valid", {31'h0, bus.out_valid}, 32'h1);
        end
      end
    join
    drain();

    // Reset with two instructions in flight
    bus.out_ready = 1'b0;
    send(ill); send(vecs[4]);
    idle();
    reset = 1'b1;
    sb.delete();
    @(posedge clk_50); #1;
    reset = 1'b0;
    @(negedge clk_50);
    chk("mrst_out_valid", {31'h0, bus.out_valid},   32'h0);
    chk("mrst_in_ready",  {31'h0, bus.in_ready},    32'h1);
    chk("mrst_count",     {24'h0, illegal_count},   32'h0);
    chk("mrst_illegal",   {31'h0, bus.out_illegal}, 32'h0);
    chk("mrst_imm",       {16'h0, bus.out_imm},     32'h0);
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk_50);
      chk("mrst_no_ghost", {31'h0, bus.out_valid}, 32'h0);
    end
    @(posedge clk_50); #1;
    send(vecs[5]);
    idle();
    drain();

    // Saturation after more than 256 illegal deliveries
    for (int i = 0; i < 300; i++) send(ill);
    idle();
    drain();
    chk("sat_count", {24'h0, illegal_count}, 32'h0000_00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
